pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter CSIZE SHALL default to 31 (PC/instruction width CSIZE+1, word-addressed PC).
REQ-002 Parameter RESET_PC SHALL default to 0 and set the PC value loaded on reset.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset; asynchronous and active-low.
REQ-005 pc  out  CSIZE+1  current fetch PC; SHALL drive the sequential incrementer input.
REQ-006 pc_plus  in  CSIZE+1  incremented PC (pc+1) returned combinationally by the sequential incrementer.
REQ-007 stall  in  1  IF/ID cannot accept an instruction this cycle.
REQ-008 branch_taken, branch_target  in  1, CSIZE+1  branch redirect request and target.
REQ-009 jump, jump_target  in  1, CSIZE+1  jump redirect request and target.
REQ-010 imem_req, imem_addr  out  1, CSIZE+1  instruction-memory request; imem_addr SHALL equal pc.
REQ-011 imem_ack, imem_data  in  1, CSIZE+1  memory completion (1+ cycles after request) and instruction word.
REQ-012 instr_valid, instr, instr_pc_plus  out  1, CSIZE+1, CSIZE+1  instruction to IF/ID, with pc_plus of its fetch address.

Function
REQ-013 FSM states SHALL be IDLE, REQ, HOLD.
REQ-014 IDLE SHALL last exactly one cycle after reset release, imem_req=0, then go to REQ.
REQ-015 REQ: imem_req SHALL be 1 and imem_addr=pc held stable until imem_ack.
REQ-016 REQ, imem_ack=1, no redirect, no pending redirect, stall=0: next cycle instr=imem_data, instr_valid=1, instr_pc_plus=pc_plus, pc<=pc_plus, remain REQ.
REQ-017 REQ, imem_ack=1, stall=1, no redirect: capture instruction into buffer, instr_valid=1, pc unchanged, go HOLD.
REQ-018 HOLD: imem_req=0; instr, instr_pc_plus, instr_valid=1 SHALL remain stable while stall=1.
REQ-019 HOLD, stall=0: buffered instruction consumed that cycle; pc<=pc_plus; next cycle instr_valid=0, go REQ.
REQ-020 instr_valid SHALL be 1 for exactly one cycle per accepted instruction when stall=0 (no duplication, no loss).
REQ-021 Redirect target priority: jump over branch_taken; target = jump_target if jump else branch_target.
REQ-022 Redirect in REQ without imem_ack: latch target in a pending register; request address SHALL not change until ack.
REQ-023 imem_ack with pending or same-cycle redirect: returned data SHALL be discarded (instr_valid=0), pc<=target (same-cycle redirect overrides pending), pending cleared, remain REQ.
REQ-024 Redirect in HOLD: buffered instruction dropped, instr_valid=0 next cycle, pc<=target, go REQ.
REQ-025 Redirect in IDLE: pc<=target, go REQ.
REQ-026 Redirect SHALL take priority over stall in every state.
REQ-027 pc_plus wrap from all-ones to 0 SHALL be accepted unmodified; no range checking.

Reset
REQ-028 On reset_n=0, immediately and independent of clk: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc_plus=0, pending redirect cleared.
REQ-029 Reset mid-transaction SHALL abandon any outstanding memory request; a late imem_ack after reset release while in IDLE SHALL be ignored.

Verification
REQ-030 Reset release, 1-cycle memory, stall=0 -> imem_addr 0,1,2,3 on consecutive requests; instr_valid pulses carry instr_pc_plus 1,2,3.
REQ-031 ack at pc=5 with stall=1 for 3 cycles -> instr held 3 cycles, pc stays 5; stall drop -> pc=6, single valid instruction observed.
REQ-032 3-cycle memory, jump=1 target 0x40 in first wait cycle -> imem_addr stays at old pc until ack, data discarded, next request at 0x40.
REQ-033 jump (0x80) and branch_taken (0x20) same cycle as ack -> data discarded, next imem_addr=0x80.
REQ-034 pc=0xFFFFFFFF, ack, stall=0 -> pc wraps to 0, instr_pc_plus=0.
REQ-035 reset_n pulsed low mid-HOLD and between clock edges -> outputs reset at once; late ack ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Instruction-fetch controller. It owns the fetch PC, issues one
// instruction-memory request at a time and hands each returned word to the
// IF/ID stage together with the incremented PC of its fetch address.
// Jump/branch redirects are honoured in every state. A redirect that arrives
// while a request is still outstanding is parked until the memory answers, and
// the stale word is then discarded.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   pc             current fetch PC (feeds the external sequential incrementer)
//   pc_plus        pc+1 returned combinationally by the incrementer
//   stall          IF/ID cannot accept an instruction this cycle
//   branch_taken   branch redirect request, target in branch_target
//   jump           jump redirect request, target in jump_target (wins over branch)
//   imem_req       instruction-memory request, address imem_addr (= pc)
//   imem_ack       memory completion, word in imem_data
//   instr_valid    instruction presented to IF/ID in instr / instr_pc_plus
module pc_fetch_ctrl #(
  parameter int               CSIZE    = 31,
  parameter logic [CSIZE:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CSIZE:0]   pc,
  input  logic [CSIZE:0]   pc_plus,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [CSIZE:0]   branch_target,
  input  logic             jump,
  input  logic [CSIZE:0]   jump_target,
  output logic             imem_req,
  output logic [CSIZE:0]   imem_addr,
  input  logic             imem_ack,
  input  logic [CSIZE:0]   imem_data,
  output logic             instr_valid,
  output logic [CSIZE:0]   instr,
  output logic [CSIZE:0]   instr_pc_plus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic           redirect;
  logic [CSIZE:0] redirect_target;

  logic           pend_valid;
  logic [CSIZE:0] pend_target;

  logic [CSIZE:0] pc_next;
  logic           pend_valid_next;
  logic [CSIZE:0] pend_target_next;
  logic           instr_valid_next;
  logic [CSIZE:0] instr_next;
  logic [CSIZE:0] instr_pc_plus_next;

  // Jump has priority over a taken branch when both are requested together.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. HOLD is only entered for a word that will really be
  // delivered, i.e. no redirect is current or parked when the ack arrives.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ack && !redirect && !pend_valid && stall) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: memory is only requested in REQ; the address is always the
  // PC, which never moves while a request is outstanding.
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  // Datapath next values. instr_valid defaults low so each accepted word is
  // presented for exactly one cycle unless it is being held for a stalled
  // IF/ID. A same-cycle redirect overrides a parked one when the ack lands.
  always_comb begin
    pc_next            = pc;
    pend_valid_next    = pend_valid;
    pend_target_next   = pend_target;
    instr_valid_next   = 1'b0;
    instr_next         = instr;
    instr_pc_plus_next = instr_pc_plus;
    case (state)
      IDLE: begin
        pend_valid_next = 1'b0;
        if (redirect) begin
          pc_next = redirect_target;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_next         = redirect_target;
            pend_valid_next = 1'b0;
          end else if (pend_valid) begin
            pc_next         = pend_target;
            pend_valid_next = 1'b0;
          end else begin
            instr_valid_next   = 1'b1;
            instr_next         = imem_data;
            instr_pc_plus_next = pc_plus;
            if (!stall) begin
              pc_next = pc_plus;
            end
          end
        end else if (redirect) begin
          pend_valid_next  = 1'b1;
          pend_target_next = redirect_target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next = redirect_target;
        end else if (!stall) begin
          pc_next = pc_plus;
        end else begin
          instr_valid_next = 1'b1;
        end
      end
      default: begin
        pend_valid_next = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      pend_valid    <= 1'b0;
      pend_target   <= '0;
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc_plus <= '0;
    end else begin
      pc            <= pc_next;
      pend_valid    <= pend_valid_next;
      pend_target   <= pend_target_next;
      instr_valid   <= instr_valid_next;
      instr         <= instr_next;
      instr_pc_plus <= instr_pc_plus_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
// Self-checking bench for pc_fetch_ctrl. A small memory responds to the
// request bus with a programmable latency; a behavioural model of the fetch
// rules predicts pc, request and delivered instructions every cycle.
module tb_pc_fetch_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus;
  logic         stall;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_data;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc_plus;

  int checks = 0;
  int errors = 0;

  // memory behaviour
  int memLat = 1;
  int memCnt = 0;

  // reference model
  logic [W-1:0] mPc;
  logic [W-1:0] mInstr;
  logic [W-1:0] mIpp;
  bit           mFresh;
  bit           mHolding;
  bit           mValid;
  logic [W-1:0] mPend[$];

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc_plus (instr_pc_plus)
  );

  // The external sequential incrementer.
  assign pc_plus = pc + 32'd1;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] memWord(input logic [W-1:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check1(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    check1("imem_req", {31'b0, imem_req}, {31'b0, !(mFresh || mHolding)});
    check1("imem_addr", imem_addr, mPc);
    check1("pc", pc, mPc);
    check1("instr_valid", {31'b0, instr_valid}, {31'b0, mValid});
    if (mValid) begin
      check1("instr", instr, mInstr);
      check1("instr_pc_plus", instr_pc_plus, mIpp);
    end
  endtask

  task automatic resetModel();
    mPc      = 32'd0;
    mFresh   = 1'b1;
    mHolding = 1'b0;
    mValid   = 1'b0;
    mInstr   = 32'd0;
    mIpp     = 32'd0;
    mPend.delete();
    memCnt   = 0;
  endtask

  // Drive one cycle of inputs, advance the model, clock, and check.
  task automatic applyStimulus(input bit st, input bit br, input logic [W-1:0] bt,
                               input bit jp, input logic [W-1:0] jt, input bit lateAck);
    bit           redir;
    bit           ack;
    logic [W-1:0] tgt;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    ack           = lateAck || (imem_req === 1'b1 && memCnt >= memLat - 1);
    imem_ack      = ack;
    imem_data     = memWord(imem_addr);
    redir         = br || jp;
    tgt           = jp ? jt : bt;

    if (mFresh) begin
      mFresh = 1'b0;
      mValid = 1'b0;
      mPend.delete();
      if (redir) mPc = tgt;
    end else if (mHolding) begin
      if (redir) begin
        mPc = tgt; mHolding = 1'b0; mValid = 1'b0;
      end else if (!st) begin
        mPc = mPc + 32'd1; mHolding = 1'b0; mValid = 1'b0;
      end
    end else if (ack) begin
      if (redir || mPend.size() > 0) begin
        mPc = redir ? tgt : mPend[0];
        mPend.delete();
        mValid = 1'b0;
      end else begin
        mValid = 1'b1;
        mInstr = memWord(mPc);
        mIpp   = mPc + 32'd1;
        if (st) mHolding = 1'b1;
        else    mPc = mPc + 32'd1;
      end
    end else begin
      mValid = 1'b0;
      if (redir) begin
        mPend.delete();
        mPend.push_back(tgt);
      end
    end

    if (imem_req === 1'b1 && !ack) memCnt++;
    else                           memCnt = 0;

    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    imem_ack      = 1'b0;
    imem_data     = '0;
    resetModel();

    // reset state
    #3;
    checkOutput();
    check1("rst_instr", instr, 32'd0);
    check1("rst_instr_pc_plus", instr_pc_plus, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;

    // single-cycle memory, free-running sequential fetch
    memLat = 1;
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

    // fetch reaching pc=5 with a three-cycle stall
    for (int i = 0; i < 20 && mPc != 32'd5; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    check1("reach_pc5", pc, 32'd5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check1("after_stall_pc", pc, 32'd6);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // three-cycle memory with a jump in the first wait cycle
    memLat = 3;
    for (int i = 0; i < 6 && memCnt != 0; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h40, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check1("jump_pending_addr", imem_addr, 32'h40);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

    // jump and branch together with the ack
    memLat = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h20, 1, 32'h80, 0);
    check1("jump_over_branch", imem_addr, 32'h80);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // PC wrap from all-ones
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check1("wrap_pc", pc, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) memLat = $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom,
                    $urandom_range(0, 9) == 0, $urandom, 0);
    end

    // asynchronous reset in the middle of a HOLD
    memLat = 1;
    for (int i = 0; i < 10 && !mHolding; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    check1("in_hold_valid", {31'b0, instr_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    resetModel();
    check1("async_rst_pc", pc, 32'd0);
    check1("async_rst_req", {31'b0, imem_req}, 32'd0);
    check1("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    check1("async_rst_instr", instr, 32'd0);
    check1("async_rst_ipp", instr_pc_plus, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
